// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: sequences FETCH/DECODE/EXEC/MEM/WB and decodes
// the datapath selects, write enables and op codes from state, opcode and funct.
module mc_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  opcode,
   input  logic [5:0]  funct,
   input  logic        zero,
   output logic [1:0]  MGRFA3,
   output logic [1:0]  MGRFWD,
   output logic        MALUB,
   output logic        GRFWE,
   output logic        DMWE,
   output logic        PCWE,
   output logic        IRWE,
   output logic [1:0]  NPCOp,
   output logic [2:0]  ALUOp,
   output logic [1:0]  EXTOp,
   output logic [2:0]  state,
   output logic        retire,
   output logic [31:0] icount
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;

   state_t cur, nxt;

   logic is_r, is_addu, is_subu, is_jr, is_ori, is_lw, is_sw;
   logic is_beq, is_lui, is_j, is_jal, is_nop;

   assign is_r    = (opcode == 6'h00);
   assign is_addu = is_r && (funct == 6'h21);
   assign is_subu = is_r && (funct == 6'h23);
   assign is_jr   = is_r && (funct == 6'h08);
   assign is_ori  = (opcode == 6'h0d);
   assign is_lw   = (opcode == 6'h23);
   assign is_sw   = (opcode == 6'h2b);
   assign is_beq  = (opcode == 6'h04);
   assign is_lui  = (opcode == 6'h0f);
   assign is_j    = (opcode == 6'h02);
   assign is_jal  = (opcode == 6'h03);
   assign is_nop  = !(is_addu || is_subu || is_jr || is_ori || is_lw || is_sw ||
                      is_beq || is_lui || is_j || is_jal);

   // ALU configuration shared by EXEC and WB so the result stays stable
   // while it is written back.
   logic [2:0] alu_cfg;
   logic       alub_cfg;
   logic [1:0] ext_cfg;

   always_comb begin
      alu_cfg  = 3'b000;
      alub_cfg = 1'b0;
      ext_cfg  = 2'b00;
      if (is_subu) begin
         alu_cfg = 3'b001;
      end else if (is_ori) begin
         alu_cfg  = 3'b010;
         alub_cfg = 1'b1;
      end else if (is_lui) begin
         alub_cfg = 1'b1;
         ext_cfg  = 2'b10;
      end else if (is_lw || is_sw) begin
         alub_cfg = 1'b1;
         ext_cfg  = 2'b01;
      end else if (is_beq) begin
         alu_cfg = 3'b001;
         ext_cfg = 2'b01;
      end
   end

   always_comb begin
      nxt    = S_FETCH;
      MGRFA3 = 2'b00;
      MGRFWD = 2'b00;
      MALUB  = 1'b0;
      GRFWE  = 1'b0;
      DMWE   = 1'b0;
      PCWE   = 1'b0;
      IRWE   = 1'b0;
      NPCOp  = 2'b00;
      ALUOp  = 3'b000;
      EXTOp  = 2'b00;
      retire = 1'b0;
      case (cur)
         S_FETCH: begin
            IRWE = 1'b1;
            PCWE = 1'b1;
            nxt  = S_DECODE;
         end
         S_DECODE: begin
            if (is_j || is_jal) begin
               PCWE   = 1'b1;
               NPCOp  = 2'b10;
               retire = 1'b1;
               if (is_jal) begin
                  GRFWE  = 1'b1;
                  MGRFA3 = 2'b10;
                  MGRFWD = 2'b10;
               end
            end else if (is_jr) begin
               PCWE   = 1'b1;
               NPCOp  = 2'b11;
               retire = 1'b1;
            end else if (is_nop) begin
               retire = 1'b1;
            end else begin
               nxt = S_EXEC;
            end
         end
         S_EXEC: begin
            ALUOp = alu_cfg;
            MALUB = alub_cfg;
            EXTOp = ext_cfg;
            if (is_beq) begin
               NPCOp  = 2'b01;
               PCWE   = zero;
               retire = 1'b1;
            end else if (is_lw || is_sw) begin
               nxt = S_MEM;
            end else begin
               nxt = S_WB;
            end
         end
         S_MEM: begin
            if (is_sw) begin
               DMWE   = 1'b1;
               retire = 1'b1;
            end else begin
               nxt = S_WB;
            end
         end
         S_WB: begin
            ALUOp  = alu_cfg;
            MALUB  = alub_cfg;
            EXTOp  = ext_cfg;
            GRFWE  = 1'b1;
            retire = 1'b1;
            MGRFA3 = (is_ori || is_lui || is_lw) ? 2'b01 : 2'b00;
            MGRFWD = is_lw ? 2'b01 : 2'b00;
         end
         default: nxt = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur    <= S_FETCH;
         icount <= 32'd0;
      end else begin
         cur <= nxt;
         if (retire) icount <= icount + 32'd1;
      end
   end

   assign state = cur;

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control unit for the MIPS datapath. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the select codes that the datapath multiplexers consume: GRF write-address select, GRF write-data select and ALU-B select. It also drives the write enables, NPC/ALU/EXT op codes, a retire pulse and a retired-instruction counter. It sits between the instruction register and the datapath.

## Interface
- No parameters.
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high; forces state and counter to reset values immediately
- opcode  input  6  instr[31:26] from IR (stable from DECODE onward)
- funct  input  6  instr[5:0] from IR
- zero  input  1  ALU equality flag, valid in EXEC
- MGRFA3  output  2  GRF A3 select: 00 rd, 01 rt, 10 $31
- MGRFWD  output  2  GRF WD select: 00 ALU result, 01 DM read data, 10 latched PC+4
- MALUB  output  1  ALU B select: 0 GRF RD2, 1 EXT output
- GRFWE, DMWE, PCWE, IRWE  output  1 each  write enables
- NPCOp  output  2  00 PC+4, 01 branch, 10 j-target, 11 GPR[rs]
- ALUOp  output  3  000 add, 001 sub, 010 or
- EXTOp  output  2  00 zero-ext, 01 sign-ext, 10 imm<<16
- state  output  3  current state: 0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB
- retire  output  1  high in the final cycle of each instruction
- icount  output  32  instructions retired since reset

## Operation
- Supported: addu (op 0, funct 0x21), subu (0/0x23), jr (0/0x08), ori 0x0d, lw 0x23, sw 0x2b, beq 0x04, lui 0x0f, j 0x02, jal 0x03. Any other opcode/funct is a NOP.
- All outputs are combinational from state, opcode and funct. Every output not listed for a state is 0 (selects are 00/0).
- FETCH: IRWE=1, PCWE=1, NPCOp=00. The datapath latches PC+4. Next state is DECODE.
- DECODE:
  - j: PCWE=1, NPCOp=10, retire. Next state is FETCH.
  - jal: as j, plus GRFWE=1, MGRFA3=10, MGRFWD=10.
  - jr: PCWE=1, NPCOp=11, retire. Next state is FETCH.
  - NOP: retire. Next state is FETCH.
  - All other instructions go to EXEC.
- EXEC:
  - addu: ALUOp=000, MALUB=0.
  - subu: ALUOp=001, MALUB=0.
  - ori: ALUOp=010, MALUB=1, EXTOp=00.
  - lui: ALUOp=000, MALUB=1, EXTOp=10.
  - lw/sw: ALUOp=000, MALUB=1, EXTOp=01. Next state is MEM.
  - beq: ALUOp=001, MALUB=0, EXTOp=01, NPCOp=01, PCWE=zero, retire. Next state is FETCH.
  - addu/subu/ori/lui go to WB.
- MEM:
  - sw: DMWE=1, retire. Next state is FETCH.
  - lw: next state is WB.
- WB:
  - GRFWE=1 and retire. Next state is FETCH.
  - addu/subu: MGRFA3=00, MGRFWD=00.
  - ori/lui: MGRFA3=01, MGRFWD=00.
  - lw: MGRFA3=01, MGRFWD=01.
  - In every case, MALUB and ALUOp hold their EXEC values.
- Illegal state codes 5–7 go to FETCH with all enables 0.
- icount increments by 1 on each rising edge where retire=1, wrapping from 0xFFFFFFFF to 0.

## Timing
- Reset values: state=FETCH, icount=0. Because outputs decode from FETCH, IRWE=1 and PCWE=1 while reset is asserted; the datapath PC/IR are themselves held in reset.
- Cycles per instruction: j/jal/jr/NOP 2, beq 3, addu/subu/ori/lui/sw 4, lw 5.
- Exactly one retire cycle per instruction. GRFWE, DMWE and PCWE are each asserted for at most one cycle per instruction, except PCWE, which is also asserted in FETCH.
- Reset asserted mid-instruction: state returns to FETCH asynchronously, no further enable is asserted for that instruction, and icount clears. The first FETCH occurs on the first rising edge after deassertion.
- beq with zero=0 still retires, with PCWE=0.

## Test plan
- Reset, then addu: states 0,1,2,4,0. In WB, GRFWE=1, MGRFA3=00, MGRFWD=00, MALUB=0, retire=1. icount goes 0→1.
- lw then sw: lw visits 0,1,2,3,4 and in WB asserts MGRFA3=01, MGRFWD=01, MALUB=1, EXTOp=01. sw asserts DMWE=1 only in MEM, with GRFWE=0 throughout. icount=2 after both.
- beq in EXEC with zero=1, then again with zero=0: first gives PCWE=1, NPCOp=01; second gives PCWE=0. Each takes 3 cycles and retires once.
- jal: in DECODE, GRFWE=1, MGRFA3=10, MGRFWD=10, PCWE=1, NPCOp=10; takes 2 cycles. jr gives NPCOp=11.
- Opcode 0x3f: 2 cycles, GRFWE=DMWE=0, and PCWE=0 in DECODE. retire=1 and icount increments.
- Assert reset during the EXEC of an ori: state=0 and icount=0 immediately, with no GRFWE pulse. After deassertion, the next instruction runs normally.
